// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   op_e     : operation code carried on the 4-bit op port
//   state_e  : sequencer state
//   is_mul_class / is_div_class : decode which latency class an op uses
// Optional feature macro: MD_MADD_EN (adds MADD/MADDU/MSUB/MSUBU to the
// multiply class).
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9,
    OP_MSUB  = 4'd10,
    OP_MSUBU = 4'd11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic is_mul_class(input op_e op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) ||
         (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_class(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational datapath of the multiply/divide unit.
//   op               : operation being started
//   src_a, src_b     : operands (rs, rt)
//   hi, lo           : current HI/LO (accumulator base for MADD/MSUB)
//   pend_hi, pend_lo : result to be committed at the end of the busy window
//   div_zero         : divide-class op with a zero divisor
// Optional feature macro: MD_MADD_EN (accumulate adder present only when set).
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] pend_hi,
  output logic [WIDTH-1:0] pend_lo,
  output logic             div_zero
);

  logic             signed_op;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, dvsr, q_mag, r_mag, quo, rem;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV) ||
                     (op == OP_MADD) || (op == OP_MSUB);

  // A single 2W-bit multiplier serves both signednesses: sign-extending the
  // operands to 2W makes the low 2W bits of the product the signed product.
  assign ext_a = signed_op ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign ext_b = signed_op ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign prod  = ext_a * ext_b;

  // Divide on magnitudes, then restore signs. This also covers MIN / -1:
  // |MIN| = 2^(W-1) and the signs agree, so the quotient wraps back to MIN.
  assign neg_a = signed_op && src_a[WIDTH-1];
  assign neg_b = signed_op && src_b[WIDTH-1];
  assign mag_a = neg_a ? (~src_a + 1'b1) : src_a;
  assign mag_b = neg_b ? (~src_b + 1'b1) : src_b;
  // Keep the divider defined on a zero divisor; the result is discarded.
  assign dvsr  = (src_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign q_mag = mag_a / dvsr;
  assign r_mag = mag_a % dvsr;
  assign quo   = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 1'b1) : r_mag;

  assign div_zero = is_div_class(op) && (src_b == '0);

  always_comb begin
    {pend_hi, pend_lo} = prod;
    case (op)
      OP_DIV, OP_DIVU: {pend_hi, pend_lo} = {rem, quo};
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: {pend_hi, pend_lo} = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: {pend_hi, pend_lo} = {hi, lo} - prod;
`endif
      default: ;
    endcase
  end

`ifndef MD_MADD_EN
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

endmodule

// File: rtl/md_unit_pipe.sv
// md_unit_pipe: multi-cycle multiply/divide unit with architectural HI/LO.
//   clk, reset    : clock; asynchronous active-high reset
//   start, op     : operation request and code (md_pkg::op_e encoding)
//   src_a, src_b  : forwarded rs/rt operands
//   cancel        : squashes a start presented in the same cycle
//   busy          : operation in flight (drives the stall unit)
//   hi, lo        : architectural HI/LO for mfhi/mflo
// Optional feature macro: MD_MADD_EN (multiply-accumulate/subtract ops).
module md_unit_pipe
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] hi_q, hi_n, lo_q, lo_n;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_n, pend_lo_q, pend_lo_n;
  logic             pend_zero_q, pend_zero_n;

  op_e              op_d;
  logic             accept;
  logic [WIDTH-1:0] a_hi, a_lo;
  logic             a_zero;

  assign op_d = op_e'(op);

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op      (op_d),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi      (hi_q),
    .lo      (lo_q),
    .pend_hi (a_hi),
    .pend_lo (a_lo),
    .div_zero(a_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_zero_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      hi_q        <= hi_n;
      lo_q        <= lo_n;
      pend_hi_q   <= pend_hi_n;
      pend_lo_q   <= pend_lo_n;
      pend_zero_q <= pend_zero_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    hi_n        = hi_q;
    lo_n        = lo_q;
    pend_hi_n   = pend_hi_q;
    pend_lo_n   = pend_lo_q;
    pend_zero_n = pend_zero_q;
    accept      = start && !cancel && (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_class(op_d) || is_div_class(op_d)) begin
            state_n     = S_RUN;
            cnt_n       = is_div_class(op_d) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
            pend_hi_n   = a_hi;
            pend_lo_n   = a_lo;
            pend_zero_n = a_zero;
          end else if (op_d == OP_MTHI) begin
            hi_n = src_a;
          end else if (op_d == OP_MTLO) begin
            lo_n = src_a;
          end
          // anything else: unsupported, ignored
        end
      end
      S_RUN: begin
        // start and cancel are both ignored here; the op already passed M
        if (cnt_q == '0) begin
          state_n = S_IDLE;
          if (!pend_zero_q) begin
            hi_n = pend_hi_q;
            lo_n = pend_lo_q;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_pipe.sv
// tb_md_unit_pipe: scoreboard bench for md_unit_pipe (WIDTH=32, 5/10 latency).
// Driver issues ops and pushes expected results from a 64-bit arithmetic
// reference model; an independent monitor checks busy length, HI/LO hold
// while busy, and the committed HI/LO when busy falls.
// Optional feature macro: MD_MADD_EN.
module tb_md_unit_pipe;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         cancel = 1'b0;
  logic         busy;
  logic [W-1:0] hi, lo;

  md_unit_pipe #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi, lo, old_hi, old_lo;
    int           lat;
  } exp_t;

  exp_t         sbq[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           run_len = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: decoupled from the driver, only looks at DUT outputs.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      run_len = 0;
    end else if (busy) begin
      run_len++;
      if (sbq.size() == 0) chk("unexpected_busy", 64'(busy), 64'd0);
      else chk("hold_hilo", {hi, lo}, {sbq[0].old_hi, sbq[0].old_lo});
    end else if (run_len > 0) begin
      if (sbq.size() == 0) chk("commit_without_op", 64'(run_len), 64'd0);
      else begin
        chk("busy_len", 64'(run_len), 64'(sbq[0].lat));
        chk("commit_hi", 64'(hi), 64'(sbq[0].hi));
        chk("commit_lo", 64'(lo), 64'(sbq[0].lo));
        void'(sbq.pop_front());
      end
      run_len = 0;
    end
  end

  function automatic bit supported(input logic [3:0] o);
    if (o >= 4'd1 && o <= 4'd6) return 1'b1;
`ifdef MD_MADD_EN
    if (o >= 4'd8 && o <= 4'd11) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
    end
  endtask

  // Issue one request at the first idle cycle and update the reference model.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit c);
    exp_t        e;
    bit          acc;
    logic [63:0] p, base;
    longint      sa, sb;
    wait_idle();
    acc = !c && supported(o);
    e.old_hi = m_hi; e.old_lo = m_lo;
    e.hi = m_hi; e.lo = m_lo; e.lat = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    base = {m_hi, m_lo};
    case (o)
      4'd1, 4'd8, 4'd10: p = 64'(sa * sb);
      default:           p = {32'd0, a} * {32'd0, b};
    endcase
    if (acc) begin
      case (o)
        4'd1, 4'd2: begin {e.hi, e.lo} = p; e.lat = ML; end
        4'd8, 4'd9: begin {e.hi, e.lo} = base + p; e.lat = ML; end
        4'd10, 4'd11: begin {e.hi, e.lo} = base - p; e.lat = ML; end
        4'd3: begin
          e.lat = DL;
          if (b != 0) begin
            e.lo = W'(sa / sb);
            e.hi = W'(sa % sb);
          end
        end
        4'd4: begin
          e.lat = DL;
          if (b != 0) begin
            e.lo = a / b;
            e.hi = a % b;
          end
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
    start = 1'b1; op = o; src_a = a; src_b = b; cancel = c;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    if (e.lat > 0) begin
      sbq.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
      chk("busy_rise", 64'(busy), 64'd1);
    end else begin
      chk("no_busy", 64'(busy), 64'd0);
      chk("direct_hi", 64'(hi), 64'(m_hi));
      chk("direct_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] c[6];
    c = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
    if ($urandom_range(0, 2) == 0) return c[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(negedge clk); @(negedge clk);
    #3 reset = 1'b0;

    // 1: signed multiply
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle();
    chk("t1_hi", 64'(hi), 64'hFFFFFFFF);
    chk("t1_lo", 64'(lo), 64'hFFFFFFFA);

    // 2: unsigned then signed divide
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    wait_idle();
    chk("t2_lo", 64'(lo), 64'd14);
    chk("t2_hi", 64'(hi), 64'd2);
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle();
    chk("t2b_lo", 64'(lo), 64'hFFFFFFFD);
    chk("t2b_hi", 64'(hi), 64'hFFFFFFFF);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    // 3: divide by zero leaves HI/LO alone
    issue(4'd5, 32'h12345678, 32'd0, 1'b0);
    issue(4'd3, 32'd5, 32'd0, 1'b0);
    wait_idle();
    chk("t3_hi", 64'(hi), 64'h12345678);
    chk("t3_lo", 64'(lo), 64'(m_lo));

    // 4: cancel on the issue cycle squashes; cancel during RUN does not
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    issue(4'd1, 32'd3, 32'd4, 1'b0);
    @(negedge clk); @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    wait_idle();
    chk("t4_lo", 64'(lo), 64'd12);
    chk("t4_hi", 64'(hi), 64'd0);

    // 5: reset in the middle of a divide
    issue(4'd3, 32'd50, 32'd3, 1'b0);
    @(negedge clk); @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_hi", 64'(hi), 64'd0);
    chk("t5_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    #3 reset = 1'b0;
    issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle();
    chk("t5b_hi", 64'(hi), 64'd1);
    chk("t5b_lo", 64'(lo), 64'hFFFFFFFE);

    // 6: accumulate ops (ignored when the feature is absent)
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue(4'd9, 32'd1, 32'd1, 1'b0);
    issue(4'd10, 32'd1, 32'd1, 1'b0);
    wait_idle();
`ifdef MD_MADD_EN
    chk("t6_hi", 64'(hi), 64'd0);
    chk("t6_lo", 64'(lo), 64'hFFFFFFFF);
`else
    chk("t6_ign_hi", 64'(hi), 64'd0);
    chk("t6_ign_lo", 64'(lo), 64'hFFFFFFFF);
`endif

    // unsupported codes
    issue(4'd0, 32'hDEAD, 32'hBEEF, 1'b0);
    issue(4'd7, 32'hDEAD, 32'hBEEF, 1'b0);
    issue(4'd15, 32'hDEAD, 32'hBEEF, 1'b0);

    // randomized back-to-back traffic
    for (int i = 0; i < 80; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 7) == 0));
    end

    wait_idle();
    @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
